// File: rtl/cl_read_reorder_buffer.sv
// Reorder buffer for CCI c0 read responses: hands out tags in order, accepts
// out-of-order responses into per-tag slots, and releases lines in tag order.
module cl_read_reorder_buffer #(
    parameter int DEPTH_LOG2 = 6,
    parameter int DATA_W     = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  alloc_req,
    output logic                  alloc_gnt,
    output logic [DEPTH_LOG2-1:0] alloc_tag,
    input  logic                  rsp_valid,
    input  logic [DEPTH_LOG2-1:0] rsp_tag,
    input  logic [DATA_W-1:0]     rsp_data,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  err_tag
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     ram [DEPTH];
    logic                  alloc_bits  [DEPTH];
    logic                  filled_bits [DEPTH];
    logic [DEPTH_LOG2-1:0] head_reg;
    logic [DEPTH_LOG2-1:0] tail_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  out_valid_reg;
    logic [DATA_W-1:0]     out_data_reg;
    logic                  err_tag_reg;

    logic grant;
    logic rsp_ok;
    logic pop;

    // Grant and pop look only at registered state, so a slot freed this cycle
    // is reusable next cycle and a freshly filled head pops one cycle later.
    assign grant  = alloc_req && (count_reg < DEPTH_CNT);
    assign rsp_ok = rsp_valid && alloc_bits[rsp_tag] && !filled_bits[rsp_tag];
    assign pop    = alloc_bits[head_reg] && filled_bits[head_reg]
                    && (!out_valid_reg || out_ready);

    assign alloc_gnt = grant;
    assign alloc_tag = tail_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign count     = count_reg;
    assign empty     = (count_reg == '0) && !out_valid_reg;
    assign err_tag   = err_tag_reg;

    always_ff @(posedge clk) begin
        if (rsp_ok) begin
            ram[rsp_tag] <= rsp_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [DEPTH_LOG2-1:0] SLOT = DEPTH_LOG2'(gi);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    alloc_bits[gi]  <= 1'b0;
                    filled_bits[gi] <= 1'b0;
                end else if (clr) begin
                    alloc_bits[gi]  <= 1'b0;
                    filled_bits[gi] <= 1'b0;
                end else begin
                    if (pop && head_reg == SLOT) begin
                        alloc_bits[gi] <= 1'b0;
                    end else if (grant && tail_reg == SLOT) begin
                        alloc_bits[gi] <= 1'b1;
                    end
                    if (pop && head_reg == SLOT) begin
                        filled_bits[gi] <= 1'b0;
                    end else if (rsp_ok && rsp_tag == SLOT) begin
                        filled_bits[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            err_tag_reg   <= 1'b0;
        end else if (clr) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            err_tag_reg   <= 1'b0;
        end else begin
            if (grant) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg      <= head_reg + 1'b1;
                out_valid_reg <= 1'b1;
                out_data_reg  <= ram[head_reg];
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            case ({grant, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (rsp_valid && !rsp_ok) begin
                err_tag_reg <= 1'b1;
            end
        end
    end
endmodule
